// File: rtl/botoes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : botoes_pkg
//  Purpose  : Shared types for the push-button controller: the per-channel
//             debounce FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package botoes_pkg;

  localparam int unsigned ESTADO_W = 3;

  // Per-channel debounce / hold state machine encoding.
  typedef enum logic [ESTADO_W-1:0] {
    SOLTO       = 3'd0,  // released, idle
    CONF_PRESS  = 3'd1,  // confirming a press
    PRESSIONADO = 3'd2,  // press accepted, counting towards long-press
    LONGO       = 3'd3,  // long-press reached, auto-repeat running
    CONF_SOLTA  = 3'd4   // confirming a release
  } estado_t;

  // True for the states in which the debounced level reads as pressed.
  function automatic logic nivel_de(input estado_t e);
    return (e == PRESSIONADO) || (e == LONGO) || (e == CONF_SOLTA);
  endfunction

endpackage : botoes_pkg
`default_nettype wire

// File: rtl/controlador_botoes_canal.sv
`default_nettype none
// ============================================================================
//  Module   : controlador_botoes_canal
//  Purpose  : One button channel: 2-flop synchroniser, debounce FSM with a
//             shared counter, and registered level / event-pulse outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module controlador_botoes_canal
  import botoes_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = 1000,
  parameter int unsigned LONGO_CICLOS    = 50000,
  parameter int unsigned REPETE_CICLOS   = 10000,
  parameter bit          REPETE_EN       = 1'b1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic b_i,
  output logic nivel_o,
  output logic press_o,
  output logic solta_o,
  output logic longo_o,
  output logic repete_o
);

  // Terminal counts, pre-sized to the counter width.
  localparam logic [CNT_W-1:0] C_DEB_FIM    = CNT_W'(DEBOUNCE_CICLOS - 1);
  localparam logic [CNT_W-1:0] C_LONGO_FIM  = CNT_W'(LONGO_CICLOS - 1);
  localparam logic [CNT_W-1:0] C_REPETE_FIM = CNT_W'(REPETE_CICLOS - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;

  logic             sync1_q;
  logic             sync2_q;
  estado_t          estado_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_d;
  logic [CNT_W-1:0] cnt_sat_d;
  logic             longo_flag_q;
  logic             nivel_q;
  logic             press_q;
  logic             solta_q;
  logic             longo_q;
  logic             repete_q;
  logic             s;

  assign s = sync2_q;

  // Counter increment candidates: plain and saturating (used while long-held
  // without auto-repeat, so the counter never wraps back into a repeat).
  always_comb begin
    cnt_inc_d = cnt_q + 1'b1;
    cnt_sat_d = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_inc_d;
  end

  // Two-flop synchroniser for the asynchronous raw button level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= b_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce / hold FSM with registered level and single-cycle event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q     <= SOLTO;
      cnt_q        <= '0;
      longo_flag_q <= 1'b0;
      nivel_q      <= 1'b0;
      press_q      <= 1'b0;
      solta_q      <= 1'b0;
      longo_q      <= 1'b0;
      repete_q     <= 1'b0;
    end else begin
      press_q  <= 1'b0;
      solta_q  <= 1'b0;
      longo_q  <= 1'b0;
      repete_q <= 1'b0;
      case (estado_q)
        SOLTO: begin
          if (s) begin
            estado_q <= CONF_PRESS;
            cnt_q    <= '0;
          end
        end
        CONF_PRESS: begin
          if (!s) begin
            estado_q <= SOLTO;
            cnt_q    <= '0;
          end else if (cnt_q == C_DEB_FIM) begin
            estado_q <= PRESSIONADO;
            cnt_q    <= '0;
            press_q  <= 1'b1;
            nivel_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        PRESSIONADO: begin
          if (!s) begin
            estado_q     <= CONF_SOLTA;
            cnt_q        <= '0;
            longo_flag_q <= 1'b0;
          end else if (cnt_q == C_LONGO_FIM) begin
            estado_q <= LONGO;
            cnt_q    <= '0;
            longo_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        LONGO: begin
          if (!s) begin
            estado_q     <= CONF_SOLTA;
            cnt_q        <= '0;
            longo_flag_q <= 1'b1;
          end else if (REPETE_EN && (cnt_q == C_REPETE_FIM)) begin
            cnt_q    <= '0;
            repete_q <= 1'b1;
          end else begin
            cnt_q <= cnt_sat_d;
          end
        end
        CONF_SOLTA: begin
          if (s) begin
            // A bounce during release resumes the hold; no new press event.
            estado_q <= longo_flag_q ? LONGO : PRESSIONADO;
            cnt_q    <= '0;
          end else if (cnt_q == C_DEB_FIM) begin
            estado_q <= SOLTO;
            cnt_q    <= '0;
            solta_q  <= 1'b1;
            nivel_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        default: begin
          estado_q <= SOLTO;
          cnt_q    <= '0;
          nivel_q  <= 1'b0;
        end
      endcase
    end
  end

  assign nivel_o  = nivel_q;
  assign press_o  = press_q;
  assign solta_o  = solta_q;
  assign longo_o  = longo_q;
  assign repete_o = repete_q;

  // The registered level must always agree with the state it was set for.
  logic nivel_coerente;
  assign nivel_coerente = (nivel_q == nivel_de(estado_q));

endmodule : controlador_botoes_canal
`default_nettype wire

// File: rtl/controlador_botoes.sv
`default_nettype none
// ============================================================================
//  Module   : controlador_botoes
//  Purpose  : N independent debounced push-button channels producing clean
//             levels and single-cycle press / release / long / repeat pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module controlador_botoes
  import botoes_pkg::*;
#(
  parameter int unsigned N_BOTOES        = 4,
  parameter int unsigned DEBOUNCE_CICLOS = 1000,
  parameter int unsigned LONGO_CICLOS    = 50000,
  parameter int unsigned REPETE_CICLOS   = 10000,
  parameter bit          REPETE_EN       = 1'b1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BOTOES-1:0] b_in,
  output logic [N_BOTOES-1:0] b_nivel,
  output logic [N_BOTOES-1:0] b_press,
  output logic [N_BOTOES-1:0] b_solta,
  output logic [N_BOTOES-1:0] b_longo,
  output logic [N_BOTOES-1:0] b_repete
);

  // One fully independent channel per button.
  for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
    controlador_botoes_canal #(
      .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
      .LONGO_CICLOS    (LONGO_CICLOS),
      .REPETE_CICLOS   (REPETE_CICLOS),
      .REPETE_EN       (REPETE_EN),
      .CNT_W           (CNT_W)
    ) u_canal (
      .clk      (clk),
      .rst      (rst),
      .b_i      (b_in[i]),
      .nivel_o  (b_nivel[i]),
      .press_o  (b_press[i]),
      .solta_o  (b_solta[i]),
      .longo_o  (b_longo[i]),
      .repete_o (b_repete[i])
    );
  end : g_canal

endmodule : controlador_botoes
`default_nettype wire
